// File: rtl/timer_ctrl_pkg.sv
// rtl/timer_ctrl_pkg.sv - shared state encoding and mode constants for timer_ctrl
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic MODE_ONE_SHOT = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - free-running 0..i_div divider producing an advance strobe
module timer_prescaler
  import timer_ctrl_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_s_rst,
  input  logic                      i_en,
  input  logic                      i_clr,
  input  logic [PRESCALE_WIDTH-1:0] i_div,
  output logic                      o_strobe
);

  logic [PRESCALE_WIDTH-1:0] r_cnt;

  assign o_strobe = i_en && (r_cnt == i_div);

  always_ff @(posedge i_clk) begin
    if (i_s_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_strobe ? '0 : r_cnt + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - one-shot/periodic timer with pause, stop and start-error pulses
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_s_rst,
  input  logic                      i_start,
  input  logic                      i_stop,
  input  logic                      i_pause,
  input  logic                      i_mode,
  input  logic [CNT_WIDTH-1:0]      i_period,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_busy,
  output logic [CNT_WIDTH-1:0]      o_value,
  output logic                      o_tick,
  output logic                      o_done,
  output logic                      o_err
);

  state_t                    r_state;
  logic                      r_mode;
  logic [CNT_WIDTH-1:0]      r_period;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [CNT_WIDTH-1:0]      r_cnt;
  logic                      r_tick;
  logic                      r_done;
  logic                      r_err;

  logic w_busy;
  logic w_en;
  logic w_clr;
  logic w_strobe;
  logic w_expire;

  assign w_busy   = (r_state == RUN) || (r_state == PAUSE);
  // Advancing on the edge that leaves PAUSE keeps the delay equal to the paused cycle count.
  assign w_en     = w_busy && !i_pause && !i_stop;
  assign w_clr    = !w_busy || i_stop;
  assign w_expire = w_strobe && (r_cnt == r_period - CNT_WIDTH'(1));

  timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .i_clk   (i_clk),
    .i_s_rst (i_s_rst),
    .i_en    (w_en),
    .i_clr   (w_clr),
    .i_div   (r_prescale),
    .o_strobe(w_strobe)
  );

  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      r_state    <= IDLE;
      r_mode     <= MODE_ONE_SHOT;
      r_period   <= '0;
      r_prescale <= '0;
      r_cnt      <= '0;
      r_tick     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (i_start && !i_stop) begin
            if (i_period != '0) begin
              r_mode     <= i_mode;
              r_period   <= i_period;
              r_prescale <= i_prescale;
              r_state    <= RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        RUN, PAUSE: begin
          if (i_stop) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            if (i_start) begin
              r_err <= 1'b1;
            end
            if (w_strobe) begin
              r_cnt <= w_expire ? '0 : r_cnt + CNT_WIDTH'(1);
            end
            if (w_expire) begin
              r_tick <= 1'b1;
            end
            if (w_expire && (r_mode == MODE_ONE_SHOT)) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_state <= i_pause ? PAUSE : RUN;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy  = w_busy;
  assign o_value = r_cnt;
  assign o_tick  = r_tick;
  assign o_done  = r_done;
  assign o_err   = r_err;

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - directed and randomized checks of timer_ctrl against an elapsed-time model
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] period = 8'd0;
  logic [7:0] prescale = 8'd0;
  logic       busy;
  logic [7:0] value;
  logic       tick;
  logic       done;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: elapsed advancing cycles since start; value and ticks follow by division.
  bit m_busy = 0;
  bit m_mode = 0;
  int m_per  = 0;
  int m_pre  = 0;
  int m_t    = 0;
  bit m_tick = 0;
  bit m_done = 0;
  bit m_err  = 0;
  int tick_cnt = 0;

  always #5 clk = ~clk;

  timer_ctrl #(
    .CNT_WIDTH(8),
    .PRESCALE_WIDTH(8)
  ) dut (
    .i_clk     (clk),
    .i_s_rst   (rst),
    .i_start   (start),
    .i_stop    (stop),
    .i_pause   (pause),
    .i_mode    (mode),
    .i_period  (period),
    .i_prescale(prescale),
    .o_busy    (busy),
    .o_value   (value),
    .o_tick    (tick),
    .o_done    (done),
    .o_err     (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    m_tick = 0;
    m_done = 0;
    m_err  = 0;
    if (rst) begin
      m_busy = 0;
      m_t    = 0;
      m_mode = 0;
      m_per  = 0;
      m_pre  = 0;
    end else if (!m_busy) begin
      if (start && !stop) begin
        if (period != 0) begin
          m_busy = 1;
          m_mode = mode;
          m_per  = int'(period);
          m_pre  = int'(prescale);
          m_t    = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (stop) begin
      m_busy = 0;
      m_t    = 0;
    end else begin
      if (start) m_err = 1;
      if (!pause) begin
        m_t++;
        if (m_t % (m_per * (m_pre + 1)) == 0) begin
          m_tick = 1;
          if (m_mode == 1'b0) begin
            m_done = 1;
            m_busy = 0;
            m_t    = 0;
          end
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit p_stop, input bit p_pause,
                     input bit md, input int per, input int pre);
    rst      = r;
    start    = s;
    stop     = p_stop;
    pause    = p_pause;
    mode     = md;
    period   = 8'(per);
    prescale = 8'(pre);
    @(posedge clk);
    #1;
    model_edge();
    if (tick) tick_cnt++;
    chk("busy",  32'(busy),  32'(m_busy));
    chk("value", 32'(value), m_busy ? 32'((m_t / (m_pre + 1)) % m_per) : 32'd0);
    chk("tick",  32'(tick),  32'(m_tick));
    chk("done",  32'(done),  32'(m_done));
    chk("err",   32'(err),   32'(m_err));
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_value", 32'(value), 32'd0);

    // One-shot period 4, prescale 0
    cyc(0, 1, 0, 0, 0, 4, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("s1_value", 32'(value), 32'(k % 4));
    end
    chk("s1_tick", 32'(tick), 32'd1);
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_busy", 32'(busy), 32'd0);
    idle_cyc(3);

    // Periodic period 3, prescale 1: three ticks then stop
    tick_cnt = 0;
    cyc(0, 1, 0, 0, 1, 3, 1);
    for (int k = 0; k < 18; k++) cyc(0, 0, 0, 0, 0, 0, 0);
    chk("s2_ticks", 32'(tick_cnt), 32'd3);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("s2_stop_busy", 32'(busy), 32'd0);
    idle_cyc(2);

    // Zero period error, then start while busy
    cyc(0, 1, 0, 0, 1, 0, 0);
    chk("s3_err", 32'(err), 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 4, 0);
    for (int k = 0; k < 6; k++) cyc(0, (k == 2), 0, 0, 1, 9, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);

    // Pause for 3 cycles mid-run, periodic period 5
    cyc(0, 1, 0, 0, 1, 5, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 12; k++) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);

    // Stop on the expiry edge, period 2
    cyc(0, 1, 0, 0, 0, 2, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("s5_no_tick", 32'(tick), 32'd0);
    idle_cyc(2);

    // Reset mid-run, then fresh one-shot
    cyc(0, 1, 0, 0, 1, 6, 2);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 4, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      cyc(($urandom_range(0, 299) == 0),
          ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 59) == 0),
          ($urandom_range(0, 6) == 0),
          1'($urandom_range(0, 1)),
          int'($urandom_range(0, 6)),
          int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
